// File: rtl/aes_pkg.sv
// aes_pkg: definitions shared by the AES status/readback block.
//   - aes_state_e     : operation-tracking FSM states
//   - AES_REG_*       : word addresses of the status register map
//   - STATUS_*_BIT    : bit positions inside the STATUS register
//   - sat_inc32()     : saturating 32-bit increment
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } aes_state_e;

  localparam logic [1:0] AES_REG_STATUS = 2'd0;
  localparam logic [1:0] AES_REG_CYCLES = 2'd1;
  localparam logic [1:0] AES_REG_OPCNT  = 2'd2;
  localparam logic [1:0] AES_REG_CTRL   = 2'd3;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_DONE_BIT  = 1;
  localparam int STATUS_ERR_BIT   = 2;
  localparam int STATUS_IRQEN_BIT = 3;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc32 = 32'hFFFF_FFFF;
    end else begin
      sat_inc32 = v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/aes_sat_counter.sv
// aes_sat_counter: up-counter with synchronous clear and enable.
// SATURATE=1 holds at all-ones, SATURATE=0 wraps modulo 2^WIDTH.
// Clear has priority over enable.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (count -> 0)
//   clr_i  : synchronous clear
//   en_i   : count enable
//   cnt_o  : current count
module aes_sat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear, then enabled increment unless pinned at saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !(SATURATE && (cnt_q == {WIDTH{1'b1}}))) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/aes_status.sv
// aes_status: read-side status block for the AES accelerator. Tracks each
// operation from the rising edge of the control register's start level to
// the core's done pulse and exposes busy/done/error flags, the latency of
// the last operation and a completed-operation count on an Avalon-MM slave.
// Optional feature macro: AES_STATUS_IRQ_EN (CTRL.irq_en and the irq output).
// Ports:
//   clk, reset                        : clock, async active-high reset
//   chipselect/read/write/address     : slave access, word index 0..3
//   writedata / readdata              : write data / registered read data
//   start                             : start level from the control register
//   done                              : single-cycle completion pulse
//   busy                              : high while an operation runs
//   irq                               : interrupt (0 without the macro)
module aes_status
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32'd4096,
  parameter int          OPCNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        start,
  input  logic        done,
  output logic        busy,
  output logic        irq
);

  aes_state_e state_q, state_d;
  logic               start_q;
  logic               busy_q, busy_d;
  logic               irq_q, irq_d;
  logic [31:0]        readdata_q, readdata_d;
  logic [31:0]        last_cycles_q, last_cycles_d;
  logic [31:0]        run_cnt;
  logic [OPCNT_W-1:0] op_cnt;
  logic               irq_en;

  logic start_rise, wr_en, w1c_done, w1c_err, timeout_hit;
  logic run_clr, run_en, op_clr, op_en;
  logic [31:0] status_word, opcnt_word;

  assign start_rise = start & ~start_q;
  assign wr_en      = chipselect & write;
  assign w1c_done   = wr_en && (address == AES_REG_STATUS) && writedata[STATUS_DONE_BIT];
  assign w1c_err    = wr_en && (address == AES_REG_STATUS) && writedata[STATUS_ERR_BIT];

  // 33-bit compare so run_cnt + 1 cannot wrap to match a small TIMEOUT.
  assign timeout_hit = (TIMEOUT != 32'd0) && !done &&
                       (({1'b0, run_cnt} + 33'd1) == {1'b0, TIMEOUT[31:0]});

`ifdef AES_STATUS_IRQ_EN
  logic irq_en_q;

  // CTRL.bit0 interrupt enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q <= 1'b0;
    end else if (wr_en && (address == AES_REG_CTRL)) begin
      irq_en_q <= writedata[0];
    end else begin
      irq_en_q <= irq_en_q;
    end
  end

  assign irq_en = irq_en_q;
`else
  assign irq_en = 1'b0;
`endif

  // Write-data bits that no register consumes.
  logic unused_wdata;
  assign unused_wdata = ^{writedata[31:3], writedata[0]};

  // FSM state register and start-level history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
    end
  end

  // FSM next state: done beats timeout in RUN, a new start beats W1C in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_rise) state_d = RUN;
        else            state_d = IDLE;
      end
      RUN: begin
        if (done)             state_d = DONE;
        else if (timeout_hit) state_d = ERR;
        else                  state_d = RUN;
      end
      DONE: begin
        if (start_rise)    state_d = RUN;
        else if (w1c_done) state_d = IDLE;
        else               state_d = DONE;
      end
      ERR: begin
        if (w1c_err) state_d = IDLE;
        else         state_d = ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: counter controls and registered flags aligned with the state.
  always_comb begin
    run_clr       = (state_d == RUN) && (state_q != RUN);
    run_en        = (state_q == RUN) && !done;
    op_en         = (state_q == RUN) && done;
    op_clr        = wr_en && (address == AES_REG_OPCNT);
    busy_d        = (state_d == RUN);
    irq_d         = ((state_d == DONE) || (state_d == ERR)) && irq_en;
    last_cycles_d = last_cycles_q;
    if (op_en) begin
      last_cycles_d = sat_inc32(run_cnt);
    end else begin
      last_cycles_d = last_cycles_q;
    end
  end

  aes_sat_counter #(.WIDTH(32), .SATURATE(1'b1)) u_run_cnt (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (run_clr),
    .en_i  (run_en),
    .cnt_o (run_cnt)
  );

  aes_sat_counter #(.WIDTH(OPCNT_W), .SATURATE(1'b0)) u_op_cnt (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (op_clr),
    .en_i  (op_en),
    .cnt_o (op_cnt)
  );

  // Read mux over pre-edge values; readdata holds when not read.
  always_comb begin
    status_word                   = 32'd0;
    status_word[STATUS_BUSY_BIT]  = (state_q == RUN);
    status_word[STATUS_DONE_BIT]  = (state_q == DONE);
    status_word[STATUS_ERR_BIT]   = (state_q == ERR);
    status_word[STATUS_IRQEN_BIT] = irq_en;
    opcnt_word                    = 32'd0;
    opcnt_word[OPCNT_W-1:0]       = op_cnt;
    readdata_d                    = readdata_q;
    if (chipselect && read) begin
      case (address)
        AES_REG_STATUS: readdata_d = status_word;
        AES_REG_CYCLES: readdata_d = last_cycles_q;
        AES_REG_OPCNT:  readdata_d = opcnt_word;
        AES_REG_CTRL:   readdata_d = {31'd0, irq_en};
        default:        readdata_d = 32'd0;
      endcase
    end else begin
      readdata_d = readdata_q;
    end
  end

  // Registered outputs and latency capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q    <= 32'd0;
      busy_q        <= 1'b0;
      irq_q         <= 1'b0;
      last_cycles_q <= 32'd0;
    end else begin
      readdata_q    <= readdata_d;
      busy_q        <= busy_d;
      irq_q         <= irq_d;
      last_cycles_q <= last_cycles_d;
    end
  end

  assign readdata = readdata_q;
  assign busy     = busy_q;
  assign irq      = irq_q;

endmodule
